// File: rtl/fib_producer.sv
// Fibonacci term producer feeding a downstream buffer on clk_1.
// Each term is handed over only on an edge where the buffer is not full.
module fib_producer #(
  parameter int DATA_W    = 16,
  parameter int MAX_TERMS = 25,
  parameter int CNT_W     = 8
) (
  input  logic              clk_1,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              buffer_full,
  output logic [DATA_W-1:0] data_1,
  output logic              data_1_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  term_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  // data_1 doubles as the "a" operand; b is the term that follows it.
  logic [DATA_W-1:0] b;
  logic              b_ovf;
  logic [DATA_W:0]   sum;
  logic [CNT_W-1:0]  cnt_inc;
  logic              last;

  assign data_1_en = (state == RUN) && !buffer_full;
  assign busy      = (state == RUN);
  assign sum       = {1'b0, data_1} + {1'b0, b};
  assign cnt_inc   = term_cnt + CNT_W'(1);
  // b_ovf marks b as unrepresentable, so the term in data_1 is the final one.
  assign last      = (cnt_inc == CNT_W'(MAX_TERMS)) || b_ovf;

  always_ff @(posedge clk_1) begin
    if (!rst) begin
      state    <= IDLE;
      data_1   <= '0;
      b        <= DATA_W'(1);
      b_ovf    <= 1'b0;
      term_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state    <= RUN;
            data_1   <= '0;
            b        <= DATA_W'(1);
            b_ovf    <= 1'b0;
            term_cnt <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            if (!buffer_full) term_cnt <= cnt_inc;
          end else if (!buffer_full) begin
            if (last) begin
              done <= 1'b1;
              if (loop_en) begin
                data_1   <= '0;
                b        <= DATA_W'(1);
                b_ovf    <= 1'b0;
                term_cnt <= '0;
              end else begin
                state    <= DONE;
                term_cnt <= cnt_inc;
              end
            end else begin
              term_cnt <= cnt_inc;
              data_1   <= b;
              b        <= sum[DATA_W-1:0];
              b_ovf    <= sum[DATA_W];
            end
          end
        end
        DONE: begin
          if (stop) begin
            state <= IDLE;
          end else if (start) begin
            state    <= RUN;
            data_1   <= '0;
            b        <= DATA_W'(1);
            b_ovf    <= 1'b0;
            term_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_producer.sv
// Self-checking bench for fib_producer: default instance plus a MAX_TERMS=10 instance
// driven from the same inputs, checked against a plain Fibonacci reference table.
module tb_fib_producer;

  logic        clk_1 = 1'b0;
  logic        rst = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0, buffer_full = 1'b0;
  logic [15:0] data_1, data_1_s;
  logic        data_1_en, busy, done, data_1_en_s, busy_s, done_s;
  logic [7:0]  term_cnt, term_cnt_s;

  int tests = 0;
  int fails = 0;
  int fib[0:29];
  int run_len;

  fib_producer u_dut (
    .clk_1(clk_1), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .buffer_full(buffer_full), .data_1(data_1), .data_1_en(data_1_en),
    .busy(busy), .done(done), .term_cnt(term_cnt)
  );

  fib_producer #(.DATA_W(16), .MAX_TERMS(10), .CNT_W(8)) u_dut10 (
    .clk_1(clk_1), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .buffer_full(buffer_full), .data_1(data_1_s), .data_1_en(data_1_en_s),
    .busy(busy_s), .done(done_s), .term_cnt(term_cnt_s)
  );

  always #5 clk_1 = ~clk_1;

  // Reference: terms by plain addition; a run is every term below 2^16, capped at 25.
  task automatic build_model();
    fib[0] = 0;
    fib[1] = 1;
    for (int i = 2; i < 30; i++) fib[i] = fib[i-1] + fib[i-2];
    run_len = 0;
    while (run_len < 25 && fib[run_len] < 65536) run_len++;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; buffer_full = 1'b0;
    repeat (2) @(negedge clk_1);
    rst = 1'b1;
    #1;
    tests++; if (data_1 !== 16'd0) begin fails++; $display("FAIL reset_data: got %0d expected 0", data_1); end
    tests++; if (data_1_en !== 1'b0) begin fails++; $display("FAIL reset_en: got %b expected 0", data_1_en); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (term_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt: got %0d expected 0", term_cnt); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    $display("[TB] reset: data=%0d en=%b busy=%b cnt=%0d", data_1, data_1_en, busy, term_cnt);
  endtask

  task automatic test_full_run();
    @(negedge clk_1); start = 1'b1;
    @(negedge clk_1); start = 1'b0;
    for (int k = 0; k < run_len; k++) begin
      #1;
      tests++; if (data_1_en !== 1'b1) begin fails++; $display("FAIL full_en k=%0d: got %b expected 1", k, data_1_en); end
      tests++; if (int'(data_1) !== fib[k]) begin fails++; $display("FAIL full_data k=%0d: got %0d expected %0d", k, data_1, fib[k]); end
      tests++; if (int'(term_cnt) !== k) begin fails++; $display("FAIL full_cnt k=%0d: got %0d expected %0d", k, term_cnt, k); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL full_early_done k=%0d: got %b expected 0", k, done); end
      $display("[TB] full xfer k=%0d data=%0d cnt=%0d", k, data_1, term_cnt);
      @(negedge clk_1);
    end
    #1;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL full_done: got %b expected 1", done); end
    tests++; if (data_1_en !== 1'b0) begin fails++; $display("FAIL full_after_en: got %b expected 0", data_1_en); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL full_after_busy: got %b expected 0", busy); end
    tests++; if (int'(data_1) !== fib[run_len-1]) begin fails++; $display("FAIL full_hold_data: got %0d expected %0d", data_1, fib[run_len-1]); end
    tests++; if (int'(term_cnt) !== run_len) begin fails++; $display("FAIL full_hold_cnt: got %0d expected %0d", term_cnt, run_len); end
    @(negedge clk_1); #1;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL full_done_pulse: got %b expected 0", done); end
    $display("[TB] full run end: done pulse seen, cnt=%0d", term_cnt);
  endtask

  task automatic test_stall();
    @(negedge clk_1); start = 1'b1;
    @(negedge clk_1); start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests++; if (int'(data_1) !== fib[k] || data_1_en !== 1'b1) begin fails++; $display("FAIL stall_pre k=%0d: got %0d/%b expected %0d/1", k, data_1, data_1_en, fib[k]); end
      @(negedge clk_1);
    end
    buffer_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      tests++; if (data_1_en !== 1'b0) begin fails++; $display("FAIL stall_en s=%0d: got %b expected 0", s, data_1_en); end
      tests++; if (int'(data_1) !== fib[2]) begin fails++; $display("FAIL stall_hold s=%0d: got %0d expected %0d", s, data_1, fib[2]); end
      tests++; if (term_cnt !== 8'd2) begin fails++; $display("FAIL stall_cnt s=%0d: got %0d expected 2", s, term_cnt); end
      $display("[TB] stall cycle s=%0d data=%0d en=%b", s, data_1, data_1_en);
      @(negedge clk_1);
    end
    buffer_full = 1'b0;
    for (int k = 2; k < 5; k++) begin
      #1;
      tests++; if (int'(data_1) !== fib[k] || data_1_en !== 1'b1) begin fails++; $display("FAIL stall_post k=%0d: got %0d/%b expected %0d/1", k, data_1, data_1_en, fib[k]); end
      $display("[TB] stall xfer k=%0d data=%0d", k, data_1);
      @(negedge clk_1);
    end
    buffer_full = 1'b1; stop = 1'b1;
    @(negedge clk_1); stop = 1'b0; buffer_full = 1'b0; #1;
    tests++; if (busy !== 1'b0 || term_cnt !== 8'd5) begin fails++; $display("FAIL stall_stop: got busy=%b cnt=%0d expected 0/5", busy, term_cnt); end
  endtask

  task automatic test_random_backpressure();
    int k;
    @(negedge clk_1); start = 1'b1;
    @(negedge clk_1); start = 1'b0;
    k = 0;
    for (int c = 0; c < 300 && k < run_len; c++) begin
      buffer_full = ($urandom_range(0, 2) == 0);
      #1;
      tests++; if (data_1_en !== !buffer_full) begin fails++; $display("FAIL rnd_en c=%0d: got %b expected %b", c, data_1_en, !buffer_full); end
      tests++; if (int'(data_1) !== fib[k]) begin fails++; $display("FAIL rnd_data c=%0d: got %0d expected %0d", c, data_1, fib[k]); end
      tests++; if (int'(term_cnt) !== k) begin fails++; $display("FAIL rnd_cnt c=%0d: got %0d expected %0d", c, term_cnt, k); end
      $display("[TB] rnd cycle c=%0d full=%b data=%0d", c, buffer_full, data_1);
      if (!buffer_full) k++;
      @(negedge clk_1);
    end
    buffer_full = 1'b0;
    #1;
    tests++; if (k !== run_len) begin fails++; $display("FAIL rnd_timeout: got %0d transfers expected %0d", k, run_len); end
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL rnd_end: got done=%b busy=%b expected 1/0", done, busy); end
  endtask

  task automatic test_loop();
    stop = 1'b1;
    @(negedge clk_1); stop = 1'b0; loop_en = 1'b1; start = 1'b1;
    @(negedge clk_1); start = 1'b0;
    for (int n = 0; n < 13; n++) begin
      #1;
      tests++; if (data_1_en_s !== 1'b1 || int'(data_1_s) !== fib[n % 10]) begin fails++; $display("FAIL loop_data n=%0d: got %0d/%b expected %0d/1", n, data_1_s, data_1_en_s, fib[n % 10]); end
      tests++; if (int'(term_cnt_s) !== n % 10) begin fails++; $display("FAIL loop_cnt n=%0d: got %0d expected %0d", n, term_cnt_s, n % 10); end
      tests++; if (done_s !== (n == 10)) begin fails++; $display("FAIL loop_done n=%0d: got %b expected %b", n, done_s, (n == 10)); end
      $display("[TB] loop xfer n=%0d data=%0d cnt=%0d done=%b", n, data_1_s, term_cnt_s, done_s);
      @(negedge clk_1);
    end
    stop = 1'b1; loop_en = 1'b0;
    @(negedge clk_1); stop = 1'b0;
  endtask

  task automatic test_stop();
    @(negedge clk_1); start = 1'b1;
    @(negedge clk_1); start = 1'b0;
    for (int k = 0; k < 6; k++) @(negedge clk_1);
    #1;
    tests++; if (data_1 !== 16'd8 || data_1_en !== 1'b1) begin fails++; $display("FAIL stop_pre: got %0d/%b expected 8/1", data_1, data_1_en); end
    stop = 1'b1;
    @(negedge clk_1); stop = 1'b0; #1;
    tests++; if (busy !== 1'b0 || data_1_en !== 1'b0) begin fails++; $display("FAIL stop_idle: got busy=%b en=%b expected 0/0", busy, data_1_en); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL stop_done: got %b expected 0", done); end
    tests++; if (term_cnt !== 8'd7) begin fails++; $display("FAIL stop_cnt: got %0d expected 7", term_cnt); end
    $display("[TB] stop: busy=%b cnt=%0d", busy, term_cnt);
  endtask

  task automatic test_mid_reset();
    @(negedge clk_1); start = 1'b1;
    @(negedge clk_1); start = 1'b0;
    for (int k = 0; k < 12; k++) @(negedge clk_1);
    #1;
    tests++; if (term_cnt !== 8'd12) begin fails++; $display("FAIL mrst_pre: got %0d expected 12", term_cnt); end
    rst = 1'b0;
    @(negedge clk_1); rst = 1'b1; #1;
    tests++; if (data_1 !== 16'd0 || term_cnt !== 8'd0) begin fails++; $display("FAIL mrst_regs: got %0d/%0d expected 0/0", data_1, term_cnt); end
    tests++; if (busy !== 1'b0 || data_1_en !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL mrst_flags: got busy=%b en=%b done=%b expected 0", busy, data_1_en, done); end
    start = 1'b1;
    @(negedge clk_1); start = 1'b0; #1;
    tests++; if (data_1 !== 16'd0 || data_1_en !== 1'b1 || term_cnt !== 8'd0) begin fails++; $display("FAIL mrst_restart: got %0d/%b/%0d expected 0/1/0", data_1, data_1_en, term_cnt); end
    $display("[TB] mid reset restart: data=%0d en=%b", data_1, data_1_en);
    stop = 1'b1;
    @(negedge clk_1); stop = 1'b0;
  endtask

  initial begin
    build_model();
    test_reset();
    test_full_run();
    test_stall();
    test_random_backpressure();
    test_loop();
    test_stop();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
